decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have port clk, in, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, in, 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port inst_fetched_in, in, inst_fetched_t, {inst[INST_LEN-1:0], valid} from fetch.
REQ-004 SHALL have port pc_in, in, ARCH_LEN, PC of inst_fetched_in.
REQ-005 SHALL have port stall_dec_in, in, 1, downstream backpressure: hold the output register.
REQ-006 SHALL have port flush_in, in, 1, taken branch (br_tk): kill the wrong-path instruction.
REQ-007 SHALL have ports wb_en, in, 1; wb_rd, in, 5; wb_data, in, ARCH_LEN; these form the register-file write port.
REQ-008 SHALL have port decoded_out, out, dec_inst_t, registered decode result: valid, pc, rs1, rs2, rd, rs1_data, rs2_data, imm, alu_op, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc, reg_write, mem_size[1:0], mem_unsigned, illegal.
REQ-009 SHALL have port stall_fet_out, out, 1, combinational; drives fetch stall_fet_in.

Function
REQ-010 SHALL decode RV32I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP into decoded_out, with 1-cycle latency: an instruction accepted at edge N is visible after edge N.
REQ-011 SHALL generate I/S/B/U/J immediates sign-extended to ARCH_LEN; B and J SHALL have bit 0 = 0.
REQ-012 SHALL set illegal=1, reg_write=0, is_load=is_store=is_branch=0 for an unknown opcode or funct3/funct7; valid SHALL still propagate.
REQ-013 SHALL force reg_write=0 when rd=0; SHALL read x0 as 0 regardless of writes.
REQ-014 SHALL bypass writeback on a same-cycle read: if wb_en and wb_rd=rsN and rsN!=0, rsN_data SHALL equal wb_data.
REQ-015 SHALL detect load-use hazard: decoded_out.valid and is_load and rd!=0 and rd equals a source actually used by the incoming valid instruction (rs1 for all types except LUI/AUIPC/JAL; rs2 only for BRANCH/STORE/OP).
REQ-016 On hazard: stall_fet_out=1; the output register SHALL load a bubble (valid=0) for exactly one cycle; the incoming instruction SHALL not be consumed.
REQ-017 On stall_dec_in=1: the output register SHALL hold, stall_fet_out=1, and the incoming instruction SHALL not be consumed.
REQ-018 On flush_in=1: the output register SHALL load valid=0 at the next edge and the incoming instruction SHALL be dropped; stall_fet_out=0.
REQ-019 Priority SHALL be rst > flush_in > stall_dec_in > hazard > normal advance.
REQ-020 inst_fetched_in.valid=0 SHALL load a bubble (valid=0), with no stall.
REQ-021 A bubble SHALL drive every decoded_out field except valid to 0 (keeps waveforms deterministic).
REQ-022 Register-file writes SHALL occur on every edge with wb_en=1 and wb_rd!=0, independent of stall and flush.

Reset
REQ-023 While rst=1 at an edge: decoded_out SHALL become all-zero (valid=0), x1..x31 SHALL clear to 0, and stall_fet_out SHALL be 0.
REQ-024 rst asserted mid-stall or mid-hazard SHALL abandon that state; the first cycle after reset SHALL accept a new instruction normally.

Structure
REQ-025 dec_inst_t, alu_op_t enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B), opcode localparams and imm-type enum SHALL live in structure_pkg/constants_pkg; ARCH_LEN and INST_LEN SHALL be reused.
REQ-026 The register file SHALL be one sub-module, regfile (2 read ports, 1 write port, with bypass), instantiated once.

Verification
REQ-027 Reset, then addi x1,x0,5 (0x00500093) valid -> next cycle rd=1, imm=5, alu_op=ADD, reg_write=1, valid=1.
REQ-028 wb_en=1, wb_rd=3, wb_data=0xDEADBEEF in the same cycle as add x4,x3,x0 -> rs1_data=0xDEADBEEF.
REQ-029 lw x5,0(x2) followed by add x6,x5,x1 -> stall_fet_out=1 for 1 cycle, one bubble, then the add appears with valid=1.
REQ-030 flush_in=1 together with stall_dec_in=1 and a valid instruction -> next cycle decoded_out.valid=0, stall_fet_out=0.
REQ-031 beq x1,x2,-8 (0xFE208CE3) -> imm=0xFFFFFFF8, is_branch=1, reg_write=0; opcode 0x7F -> illegal=1.
REQ-032 Writes to x0 with wb_data=0x1234, then read x0 -> rs1_data=0.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared types and constants for the RV32I decode stage: instruction and
// decode-result structs, ALU op and immediate-type enums, opcode values.
package decode_stage_pkg;

  localparam int ARCH_LEN = 32;
  localparam int INST_LEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  // ALU_ADD is encoded as 0 so an all-zero bubble reads as a plain ADD.
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_type_t;

  typedef struct packed {
    logic [INST_LEN-1:0] inst;
    logic                valid;
  } inst_fetched_t;

  typedef struct packed {
    logic                valid;
    logic [ARCH_LEN-1:0] pc;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [ARCH_LEN-1:0] rs1_data;
    logic [ARCH_LEN-1:0] rs2_data;
    logic [ARCH_LEN-1:0] imm;
    alu_op_t             alu_op;
    logic                is_load;
    logic                is_store;
    logic                is_branch;
    logic                is_jal;
    logic                is_jalr;
    logic                is_lui;
    logic                is_auipc;
    logic                reg_write;
    logic [1:0]          mem_size;
    logic                mem_unsigned;
    logic                illegal;
  } dec_inst_t;

  function automatic logic [ARCH_LEN-1:0] imm_gen(input logic [INST_LEN-1:0] inst,
                                                  input imm_type_t sel);
    case (sel)
      IMM_I:   return {{20{inst[31]}}, inst[31:20]};
      IMM_S:   return {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   return {inst[31:12], 12'b0};
      IMM_J:   return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// 32 x ARCH_LEN integer register file: two read ports, one write port,
// x0 hard-wired to zero, same-cycle write-to-read bypass.
module regfile
  import decode_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          rs1_addr,
  output logic [ARCH_LEN-1:0] rs1_data,
  input  logic [4:0]          rs2_addr,
  output logic [ARCH_LEN-1:0] rs2_data,
  input  logic                wr_en,
  input  logic [4:0]          wr_addr,
  input  logic [ARCH_LEN-1:0] wr_data
);

  logic [ARCH_LEN-1:0] regs [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != 5'd0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rs1_data = regs[rs1_addr];
    rs2_data = regs[rs2_addr];
    if (wr_en && (wr_addr == rs1_addr)) rs1_data = wr_data;
    if (wr_en && (wr_addr == rs2_addr)) rs2_data = wr_data;
    if (rs1_addr == 5'd0) rs1_data = '0;
    if (rs2_addr == 5'd0) rs2_data = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes the fetched instruction into a registered
// dec_inst_t, reads operands, and stalls fetch on backpressure or load-use.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  inst_fetched_t       inst_fetched_in,
  input  logic [ARCH_LEN-1:0] pc_in,
  input  logic                stall_dec_in,
  input  logic                flush_in,
  input  logic                wb_en,
  input  logic [4:0]          wb_rd,
  input  logic [ARCH_LEN-1:0] wb_data,
  output dec_inst_t           decoded_out,
  output logic                stall_fet_out
);

  logic [INST_LEN-1:0] inst;
  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [6:0]          funct7;
  logic [4:0]          rs1, rs2, rd;
  logic [ARCH_LEN-1:0] rs1_data, rs2_data;
  logic                legal, writes_rd;
  imm_type_t           imm_sel;
  logic                uses_rs1, uses_rs2, hazard;
  dec_inst_t           dec_next, dec_q;

  assign inst   = inst_fetched_in.inst;
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];

  regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1),
    .rs1_data (rs1_data),
    .rs2_addr (rs2),
    .rs2_data (rs2_data),
    .wr_en    (wb_en),
    .wr_addr  (wb_rd),
    .wr_data  (wb_data)
  );

  always_comb begin
    dec_next          = '0;
    legal             = 1'b0;
    writes_rd         = 1'b0;
    imm_sel           = IMM_NONE;
    dec_next.valid    = 1'b1;
    dec_next.pc       = pc_in;
    dec_next.rs1      = rs1;
    dec_next.rs2      = rs2;
    dec_next.rd       = rd;
    dec_next.rs1_data = rs1_data;
    dec_next.rs2_data = rs2_data;
    dec_next.alu_op   = ALU_ADD;
    case (opcode)
      OPC_LUI: begin
        legal = 1'b1; writes_rd = 1'b1; imm_sel = IMM_U;
        dec_next.is_lui = 1'b1;
        dec_next.alu_op = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        legal = 1'b1; writes_rd = 1'b1; imm_sel = IMM_U;
        dec_next.is_auipc = 1'b1;
      end
      OPC_JAL: begin
        legal = 1'b1; writes_rd = 1'b1; imm_sel = IMM_J;
        dec_next.is_jal = 1'b1;
      end
      OPC_JALR: begin
        legal = (funct3 == 3'd0); writes_rd = 1'b1; imm_sel = IMM_I;
        dec_next.is_jalr = 1'b1;
      end
      OPC_BRANCH: begin
        legal = (funct3 != 3'd2) && (funct3 != 3'd3); imm_sel = IMM_B;
        dec_next.is_branch = 1'b1;
        dec_next.alu_op = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
      end
      OPC_LOAD: begin
        legal = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
        writes_rd = 1'b1; imm_sel = IMM_I;
        dec_next.is_load      = 1'b1;
        dec_next.mem_size     = funct3[1:0];
        dec_next.mem_unsigned = funct3[2];
      end
      OPC_STORE: begin
        legal = (funct3 < 3'd3); imm_sel = IMM_S;
        dec_next.is_store = 1'b1;
        dec_next.mem_size = funct3[1:0];
      end
      OPC_OPIMM: begin
        legal = 1'b1; writes_rd = 1'b1; imm_sel = IMM_I;
        case (funct3)
          3'd0: dec_next.alu_op = ALU_ADD;
          3'd1: begin dec_next.alu_op = ALU_SLL; legal = (funct7 == 7'h00); end
          3'd2: dec_next.alu_op = ALU_SLT;
          3'd3: dec_next.alu_op = ALU_SLTU;
          3'd4: dec_next.alu_op = ALU_XOR;
          3'd5: begin
            dec_next.alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
            legal = (funct7 == 7'h00) || (funct7 == 7'h20);
          end
          3'd6: dec_next.alu_op = ALU_OR;
          default: dec_next.alu_op = ALU_AND;
        endcase
      end
      OPC_OP: begin
        legal = 1'b1; writes_rd = 1'b1;
        case ({funct7, funct3})
          {7'h00, 3'd0}: dec_next.alu_op = ALU_ADD;
          {7'h20, 3'd0}: dec_next.alu_op = ALU_SUB;
          {7'h00, 3'd1}: dec_next.alu_op = ALU_SLL;
          {7'h00, 3'd2}: dec_next.alu_op = ALU_SLT;
          {7'h00, 3'd3}: dec_next.alu_op = ALU_SLTU;
          {7'h00, 3'd4}: dec_next.alu_op = ALU_XOR;
          {7'h00, 3'd5}: dec_next.alu_op = ALU_SRL;
          {7'h20, 3'd5}: dec_next.alu_op = ALU_SRA;
          {7'h00, 3'd6}: dec_next.alu_op = ALU_OR;
          {7'h00, 3'd7}: dec_next.alu_op = ALU_AND;
          default:       legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    if (legal) begin
      dec_next.imm       = imm_gen(inst, imm_sel);
      dec_next.reg_write = writes_rd && (rd != 5'd0);
    end else begin
      // Illegal still flows down the pipe (for the trap), but with no side effects.
      dec_next.alu_op       = ALU_ADD;
      dec_next.is_load      = 1'b0;
      dec_next.is_store     = 1'b0;
      dec_next.is_branch    = 1'b0;
      dec_next.is_jal       = 1'b0;
      dec_next.is_jalr      = 1'b0;
      dec_next.is_lui       = 1'b0;
      dec_next.is_auipc     = 1'b0;
      dec_next.mem_size     = 2'd0;
      dec_next.mem_unsigned = 1'b0;
      dec_next.illegal      = 1'b1;
    end
  end

  assign uses_rs1 = (opcode != OPC_LUI) && (opcode != OPC_AUIPC) && (opcode != OPC_JAL);
  assign uses_rs2 = (opcode == OPC_BRANCH) || (opcode == OPC_STORE) || (opcode == OPC_OP);
  assign hazard   = inst_fetched_in.valid && dec_q.valid && dec_q.is_load &&
                    (dec_q.rd != 5'd0) &&
                    ((uses_rs1 && (rs1 == dec_q.rd)) || (uses_rs2 && (rs2 == dec_q.rd)));

  assign stall_fet_out = !rst && !flush_in && (stall_dec_in || hazard);

  always_ff @(posedge clk) begin
    if (rst || flush_in) begin
      dec_q <= '0;
    end else if (!stall_dec_in) begin
      if (hazard || !inst_fetched_in.valid) dec_q <= '0;
      else                                  dec_q <= dec_next;
    end
  end

  assign decoded_out = dec_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios then random
// traffic, all compared against an instruction-level reference model.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  inst_fetched_t inst_fetched_in;
  logic [31:0]   pc_in;
  logic          stall_dec_in, flush_in, wb_en;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_data;
  dec_inst_t     decoded_out;
  logic          stall_fet_out;

  int          n_cmp = 0;
  int          n_bad = 0;
  dec_inst_t   m_out;
  logic [31:0] m_rf [32];
  logic        obs_stall;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk             (clk),
    .rst             (rst),
    .inst_fetched_in (inst_fetched_in),
    .pc_in           (pc_in),
    .stall_dec_in    (stall_dec_in),
    .flush_in        (flush_in),
    .wb_en           (wb_en),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .decoded_out     (decoded_out),
    .stall_fet_out   (stall_fet_out)
  );

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] r, input logic we,
                                             input logic [4:0] wrd, input logic [31:0] wd);
    if (r == 5'd0) return 32'd0;
    if (we && wrd == r) return wd;
    return m_rf[r];
  endfunction

  // Reference decode, written from the ISA's instruction classes.
  function automatic dec_inst_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                           input logic [31:0] d1, input logic [31:0] d2);
    dec_inst_t          e, bad;
    logic signed [31:0] si;
    logic [31:0]        i_imm, s_imm, b_imm, u_imm, j_imm;
    int                 f3, f7;
    bit                 ok, wr;
    alu_op_t            tbl [8];
    tbl   = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    si    = ins;
    f3    = int'(ins[14:12]);
    f7    = int'(ins[31:25]);
    i_imm = 32'(si >>> 20);
    s_imm = (32'(si >>> 25) << 5) | 32'(ins[11:7]);
    b_imm = (32'(si >>> 31) << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
    u_imm = ins & 32'hFFFF_F000;
    j_imm = (32'(si >>> 31) << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
    e = '0;
    e.valid = 1'b1; e.pc = pc;
    e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
    e.rs1_data = d1; e.rs2_data = d2;
    bad = e;
    bad.illegal = 1'b1;
    ok = 1'b1; wr = 1'b0;
    case (ins[6:0])
      7'h37: begin e.is_lui = 1; wr = 1; e.alu_op = ALU_PASS_B; e.imm = u_imm; end
      7'h17: begin e.is_auipc = 1; wr = 1; e.imm = u_imm; end
      7'h6F: begin e.is_jal = 1; wr = 1; e.imm = j_imm; end
      7'h67: begin e.is_jalr = 1; wr = 1; e.imm = i_imm; ok = (f3 == 0); end
      7'h63: begin
        e.is_branch = 1; e.imm = b_imm; ok = !(f3 == 2 || f3 == 3);
        e.alu_op = (f3 < 2) ? ALU_SUB : (f3 < 6) ? ALU_SLT : ALU_SLTU;
      end
      7'h03: begin
        e.is_load = 1; wr = 1; e.imm = i_imm; ok = (f3 inside {0, 1, 2, 4, 5});
        e.mem_size = 2'(f3 % 4); e.mem_unsigned = (f3 >= 4);
      end
      7'h23: begin e.is_store = 1; e.imm = s_imm; ok = (f3 < 3); e.mem_size = 2'(f3 % 4); end
      7'h13: begin
        wr = 1; e.imm = i_imm; e.alu_op = tbl[f3];
        if (f3 == 1) ok = (f7 == 0);
        if (f3 == 5) begin ok = (f7 == 0 || f7 == 32); if (f7 == 32) e.alu_op = ALU_SRA; end
      end
      7'h33: begin
        wr = 1;
        if (f7 == 0) e.alu_op = tbl[f3];
        else if (f7 == 32 && f3 == 0) e.alu_op = ALU_SUB;
        else if (f7 == 32 && f3 == 5) e.alu_op = ALU_SRA;
        else ok = 0;
      end
      default: ok = 0;
    endcase
    if (!ok) return bad;
    e.reg_write = wr && (e.rd != 5'd0);
    return e;
  endfunction

  task automatic cycle(input logic r, input logic v, input logic [31:0] ins, input logic st,
                       input logic fl, input logic we, input logic [4:0] wrd, input logic [31:0] wd);
    logic [31:0] d1, d2, pc;
    logic [6:0]  opc;
    logic        haz, exp_stall, src1, src2;
    @(negedge clk);
    pc = $urandom & 32'hFFFF_FFFC;
    rst = r; inst_fetched_in.inst = ins; inst_fetched_in.valid = v; pc_in = pc;
    stall_dec_in = st; flush_in = fl; wb_en = we; wb_rd = wrd; wb_data = wd;
    d1   = model_read(ins[19:15], we, wrd, wd);
    d2   = model_read(ins[24:20], we, wrd, wd);
    opc  = ins[6:0];
    src1 = !(opc inside {7'h37, 7'h17, 7'h6F}) && (ins[19:15] == m_out.rd);
    src2 = (opc inside {7'h63, 7'h23, 7'h33}) && (ins[24:20] == m_out.rd);
    haz  = v && m_out.valid && m_out.is_load && (m_out.rd != 5'd0) && (src1 || src2);
    exp_stall = !r && !fl && (st || haz);
    #1;
    obs_stall = stall_fet_out;
    check_val("stall_fet_out", 256'(stall_fet_out), 256'(exp_stall));
    if (r || fl)        m_out = '0;
    else if (st)        m_out = m_out;
    else if (haz || !v) m_out = '0;
    else                m_out = ref_decode(ins, pc, d1, d2);
    if (r) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    end else if (we && wrd != 5'd0) begin
      m_rf[wrd] = wd;
    end
    @(posedge clk);
    #1;
    check_val("decoded_out", 256'(decoded_out), 256'(m_out));
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [9];
    logic [31:0] ins;
    int          k;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    k   = $urandom_range(0, 9);
    ins = $urandom;
    ins[6:0] = (k == 9) ? 7'($urandom) : ops[k];
    if ($urandom_range(0, 3) != 0) begin
      ins[11:7]  = 5'($urandom_range(0, 5));
      ins[19:15] = 5'($urandom_range(0, 5));
      ins[24:20] = 5'($urandom_range(0, 5));
    end
    case ($urandom_range(0, 3))
      0, 1:    ins[31:25] = 7'h00;
      2:       ins[31:25] = 7'h20;
      default: ;
    endcase
    return ins;
  endfunction

  initial begin
    rst = 1'b1; inst_fetched_in = '0; pc_in = '0; stall_dec_in = 0; flush_in = 0;
    wb_en = 0; wb_rd = '0; wb_data = '0; m_out = '0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;

    cycle(1, 0, 32'h0, 0, 0, 0, 0, 0);
    cycle(1, 1, 32'h00500093, 1, 0, 1, 5'd7, 32'h55);
    check_val("reset_valid", 256'(decoded_out.valid), 256'(1'b0));
    check_val("reset_stall", 256'(obs_stall), 256'(1'b0));

    // addi x1,x0,5
    cycle(0, 1, 32'h00500093, 0, 0, 0, 0, 0);
    check_val("addi_rd", 256'(decoded_out.rd), 256'(5'd1));
    check_val("addi_imm", 256'(decoded_out.imm), 256'(32'd5));
    check_val("addi_alu", 256'(decoded_out.alu_op), 256'(ALU_ADD));
    check_val("addi_rw", 256'({decoded_out.reg_write, decoded_out.valid}), 256'(2'b11));

    // add x4,x3,x0 with same-cycle writeback of x3
    cycle(0, 1, 32'h00018233, 0, 0, 1, 5'd3, 32'hDEADBEEF);
    check_val("bypass_rs1", 256'(decoded_out.rs1_data), 256'(32'hDEADBEEF));

    // lw x5,0(x2) ; add x6,x5,x1
    cycle(0, 1, 32'h00012283, 0, 0, 0, 0, 0);
    cycle(0, 1, 32'h00128333, 0, 0, 0, 0, 0);
    check_val("loaduse_stall", 256'(obs_stall), 256'(1'b1));
    check_val("loaduse_bubble", 256'(decoded_out.valid), 256'(1'b0));
    cycle(0, 1, 32'h00128333, 0, 0, 0, 0, 0);
    check_val("loaduse_release", 256'(obs_stall), 256'(1'b0));
    check_val("loaduse_add", 256'({decoded_out.valid, decoded_out.rd}), 256'({1'b1, 5'd6}));

    // flush beats stall
    cycle(0, 1, 32'h00500093, 1, 1, 0, 0, 0);
    check_val("flush_valid", 256'(decoded_out.valid), 256'(1'b0));
    check_val("flush_stall", 256'(obs_stall), 256'(1'b0));

    // beq x1,x2,-8 then unknown opcode
    cycle(0, 1, 32'hFE208CE3, 0, 0, 0, 0, 0);
    check_val("beq_imm", 256'(decoded_out.imm), 256'(32'hFFFFFFF8));
    check_val("beq_ctl", 256'({decoded_out.is_branch, decoded_out.reg_write}), 256'(2'b10));
    cycle(0, 1, 32'h0000007F, 0, 0, 0, 0, 0);
    check_val("opc7f_illegal", 256'({decoded_out.illegal, decoded_out.valid}), 256'(2'b11));

    // writes to x0 are discarded, including the bypass path
    cycle(0, 1, 32'h00000233, 0, 0, 1, 5'd0, 32'h1234);
    check_val("x0_bypass", 256'(decoded_out.rs1_data), 256'(32'd0));
    cycle(0, 1, 32'h00000233, 0, 0, 0, 0, 0);
    check_val("x0_read", 256'(decoded_out.rs1_data), 256'(32'd0));

    // reset during a load-use hazard, then normal acceptance
    cycle(0, 1, 32'h00012283, 0, 0, 0, 0, 0);
    cycle(1, 1, 32'h00128333, 0, 0, 0, 0, 0);
    check_val("rst_hazard_stall", 256'(obs_stall), 256'(1'b0));
    cycle(0, 1, 32'h00128333, 0, 0, 0, 0, 0);
    check_val("post_rst_accept", 256'({obs_stall, decoded_out.valid}), 256'(2'b01));

    // random traffic; fetch holds its instruction while stalled
    begin
      logic [31:0] ins;
      logic        v;
      ins = rand_inst();
      v   = 1'b1;
      for (int n = 0; n < 4000; n++) begin
        if (!obs_stall) begin
          ins = rand_inst();
          v   = ($urandom_range(0, 7) != 0);
        end
        cycle(($urandom_range(0, 199) == 0), v, ins,
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0),
              ($urandom_range(0, 1) == 0), 5'($urandom_range(0, 7)), $urandom);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
